// File: rtl/anita_l2_coincidence.sv
// anita_l2_coincidence
//   NPHI-sector L2 coincidence engine. Each phi sector detects rising edges on
//   its top/middle/bottom L1 flags, forms the ring-to-ring coincidences enabled
//   by mode_i, and drives a fixed-width L2 pulse plus a saturating L2 counter.
//   Sectors are independent; one anita_l2_sector instance per sector.
// Ports
//   clk_i, rst_i                 trigger clock, synchronous active-high reset
//   l1_top_i/l1_mid_i/l1_bot_i   per-sector L1 flags (bit p = sector p)
//   mode_i                       bit0 top-mid, bit1 top-bot, bit2 mid-bot enable
//   mask_i                       1 = discard that sector's hits
//   force_i                      1 = inject a hit for that sector
//   cnt_clr_i                    clear all L2 counters
//   trig_o                       L2 pulse per sector, L2_WIDTH cycles
//   l2_cnt_o                     sector p count at [p*CNT_W +: CNT_W]

module anita_l2_sector #(
   parameter int MID_TOP_WIN = 2,
   parameter int BOT_TOP_WIN = 3,
   parameter int BOT_MID_WIN = 1,
   parameter int L2_WIDTH    = 3,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             top_i,
   input  logic             mid_i,
   input  logic             bot_i,
   input  logic [2:0]       mode_i,
   input  logic             mask_i,
   input  logic             frc_i,
   input  logic             clr_i,
   output logic             trig_o,
   output logic [CNT_W-1:0] cnt_o
);
   localparam int MID_MAX = (MID_TOP_WIN > BOT_MID_WIN) ? MID_TOP_WIN : BOT_MID_WIN;
   localparam int BOT_MAX = (BOT_TOP_WIN > BOT_MID_WIN) ? BOT_TOP_WIN : BOT_MID_WIN;
   localparam int AGE_MAX = (MID_MAX > BOT_MAX) ? MID_MAX : BOT_MAX;
   localparam int AW      = $clog2(AGE_MAX + 2);
   localparam int WW      = (L2_WIDTH > 1) ? $clog2(L2_WIDTH) : 1;

   localparam logic [AW-1:0] AGE_SAT = AW'(AGE_MAX);
   localparam logic [AW-1:0] MT_A    = AW'(MID_TOP_WIN);
   localparam logic [AW-1:0] BT_A    = AW'(BOT_TOP_WIN);
   localparam logic [AW-1:0] BM_A    = AW'(BOT_MID_WIN);

   typedef enum logic {IDLE, FIRE} state_t;

   logic [2:0]       prev_q;               // {bot, mid, top} previous sample
   // Age = cycles since the ring's last event minus one; AGE_SAT means "too old".
   // An event sampled now against an age register value a is a+1 cycles apart.
   logic [AW-1:0]    mid_age_q, bot_age_q;
   logic [1:0]       vld_pipe;             // masked hit delayed to the FSM
   state_t           state_q;
   logic [WW-1:0]    wcnt_q;
   logic             trig_q;
   logic [CNT_W-1:0] cnt_q;

   logic top_ev, mid_ev, bot_ev, co_tm, co_tb, co_mb, hit;

   always_comb begin
      top_ev = top_i & ~prev_q[0];
      mid_ev = mid_i & ~prev_q[1];
      bot_ev = bot_i & ~prev_q[2];
      // Top only ever completes; mid-bot can complete from either side.
      co_tm  = top_ev & (mid_ev | (mid_age_q < MT_A));
      co_tb  = top_ev & (bot_ev | (bot_age_q < BT_A));
      co_mb  = (mid_ev & (bot_ev | (bot_age_q < BM_A))) |
               (bot_ev & (mid_age_q < BM_A));
      hit    = (mode_i[0] & co_tm) | (mode_i[1] & co_tb) | (mode_i[2] & co_mb) | frc_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q    <= '0;
         mid_age_q <= AGE_SAT;
         bot_age_q <= AGE_SAT;
         vld_pipe  <= '0;
         state_q   <= IDLE;
         wcnt_q    <= '0;
         trig_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         prev_q    <= {bot_i, mid_i, top_i};
         mid_age_q <= mid_ev ? '0 : ((mid_age_q == AGE_SAT) ? mid_age_q : mid_age_q + 1'b1);
         bot_age_q <= bot_ev ? '0 : ((bot_age_q == AGE_SAT) ? bot_age_q : bot_age_q + 1'b1);
         vld_pipe  <= {vld_pipe[0], hit & ~mask_i};
         case (state_q)
            IDLE: if (vld_pipe[1]) begin
               state_q <= FIRE;
               wcnt_q  <= WW'(L2_WIDTH - 1);
               trig_q  <= 1'b1;
               if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
            FIRE: begin
               // Hits arriving here are dropped.
               if (wcnt_q == '0) begin
                  state_q <= IDLE;
                  trig_q  <= 1'b0;
               end else begin
                  wcnt_q <= wcnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
         if (clr_i) cnt_q <= '0;
      end
   end

   assign trig_o = trig_q;
   assign cnt_o  = cnt_q;
endmodule

module anita_l2_coincidence #(
   parameter int NPHI        = 2,
   parameter int MID_TOP_WIN = 2,
   parameter int BOT_TOP_WIN = 3,
   parameter int BOT_MID_WIN = 1,
   parameter int L2_WIDTH    = 3,
   parameter int CNT_W       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NPHI-1:0]       l1_top_i,
   input  logic [NPHI-1:0]       l1_mid_i,
   input  logic [NPHI-1:0]       l1_bot_i,
   input  logic [2:0]            mode_i,
   input  logic [NPHI-1:0]       mask_i,
   input  logic [NPHI-1:0]       force_i,
   input  logic                  cnt_clr_i,
   output logic [NPHI-1:0]       trig_o,
   output logic [NPHI*CNT_W-1:0] l2_cnt_o
);
   for (genvar p = 0; p < NPHI; p++) begin : g_sec
      anita_l2_sector #(
         .MID_TOP_WIN (MID_TOP_WIN),
         .BOT_TOP_WIN (BOT_TOP_WIN),
         .BOT_MID_WIN (BOT_MID_WIN),
         .L2_WIDTH    (L2_WIDTH),
         .CNT_W       (CNT_W)
      ) u_sec (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .top_i  (l1_top_i[p]),
         .mid_i  (l1_mid_i[p]),
         .bot_i  (l1_bot_i[p]),
         .mode_i (mode_i),
         .mask_i (mask_i[p]),
         .frc_i  (force_i[p]),
         .clr_i  (cnt_clr_i),
         .trig_o (trig_o[p]),
         .cnt_o  (l2_cnt_o[p*CNT_W +: CNT_W])
      );
   end
endmodule
